// File: rtl/uart_packet_tx_arbiter.sv
// Shares one uart_tx between a command and a response packet source.
// Each granted packet is sent one byte at a time through the load/start/finish handshake.
module uart_packet_tx_arbiter #(
  parameter int PKT_BYTES   = 18,
  parameter int LEN_W       = 5,
  parameter int HOLD_CYCLES = 5208,
  parameter int TIMEOUT     = 4000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   soft_reset,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [8*PKT_BYTES-1:0] pkt0,
  input  logic [8*PKT_BYTES-1:0] pkt1,
  input  logic [LEN_W-1:0]       len0,
  input  logic [LEN_W-1:0]       len1,
  output logic                   grant0,
  output logic                   grant1,
  output logic                   done0,
  output logic                   done1,
  output logic                   error,
  output logic                   busy,
  output logic [7:0]             uart_data,
  output logic                   uart_load_data,
  output logic                   uart_start_transmit,
  input  logic                   uart_tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IDLE,
    LOAD,
    START,
    WAIT_DONE,
    FINISH
  } state_t;

  localparam logic [31:0]      HOLD_LAST    = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT - 1);
  localparam logic [LEN_W-1:0] MAX_LEN      = LEN_W'(PKT_BYTES);

  state_t                 state;
  logic [8*PKT_BYTES-1:0] pkt_q;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       idx;
  logic                   owner;
  logic                   last_grant;
  logic                   err_flag;
  logic [31:0]            timer;
  logic                   tx_done_meta;
  logic                   tx_done_sync;

  logic                   any_req;
  logic                   pick;
  logic [LEN_W-1:0]       pick_len;
  logic                   timed_out;

  function automatic logic [7:0] byte_at(input logic [8*PKT_BYTES-1:0] p,
                                         input logic [LEN_W-1:0] i);
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < PKT_BYTES; k++) begin
      if (i == LEN_W'(k)) b = p[8*k +: 8];
    end
    return b;
  endfunction

  // On a tie the requester that was not served last wins.
  always_comb begin
    any_req  = req0 | req1;
    pick     = (req0 && req1) ? ~last_grant : req1;
    pick_len = pick ? len1 : len0;
  end

  assign timed_out = (timer >= TIMEOUT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_done_meta <= 1'b0;
      tx_done_sync <= 1'b0;
    end else begin
      tx_done_meta <= uart_tx_done;
      tx_done_sync <= tx_done_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      pkt_q               <= '0;
      len_q               <= '0;
      idx                 <= '0;
      owner               <= 1'b0;
      last_grant          <= 1'b1;
      err_flag            <= 1'b0;
      timer               <= '0;
      grant0              <= 1'b0;
      grant1              <= 1'b0;
      done0               <= 1'b0;
      done1               <= 1'b0;
      error               <= 1'b0;
      busy                <= 1'b0;
      uart_data           <= '0;
      uart_load_data      <= 1'b0;
      uart_start_transmit <= 1'b0;
    end else if (soft_reset) begin
      state               <= IDLE;
      pkt_q               <= '0;
      len_q               <= '0;
      idx                 <= '0;
      owner               <= 1'b0;
      last_grant          <= 1'b1;
      err_flag            <= 1'b0;
      timer               <= '0;
      grant0              <= 1'b0;
      grant1              <= 1'b0;
      done0               <= 1'b0;
      done1               <= 1'b0;
      error               <= 1'b0;
      busy                <= 1'b0;
      uart_data           <= '0;
      uart_load_data      <= 1'b0;
      uart_start_transmit <= 1'b0;
    end else begin
      grant0 <= 1'b0;
      grant1 <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      error  <= 1'b0;
      timer  <= timer + 32'd1;
      case (state)
        IDLE: begin
          timer <= '0;
          if (any_req) begin
            grant0 <= ~pick;
            grant1 <= pick;
            owner  <= pick;
            pkt_q  <= pick ? pkt1 : pkt0;
            len_q  <= pick_len;
            idx    <= '0;
            busy   <= 1'b1;
            // Out-of-range lengths are reported without touching the UART.
            if (pick_len == '0 || pick_len > MAX_LEN) begin
              err_flag <= 1'b1;
              state    <= FINISH;
            end else begin
              state <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (tx_done_sync) begin
            uart_data      <= byte_at(pkt_q, idx);
            uart_load_data <= 1'b1;
            timer          <= '0;
            state          <= LOAD;
          end else if (timed_out) begin
            err_flag <= 1'b1;
            timer    <= '0;
            state    <= FINISH;
          end
        end
        LOAD: begin
          if (timer >= HOLD_LAST) begin
            uart_load_data      <= 1'b0;
            uart_start_transmit <= 1'b1;
            timer               <= '0;
            state               <= START;
          end
        end
        START: begin
          if (!tx_done_sync) begin
            uart_start_transmit <= 1'b0;
            timer               <= '0;
            state               <= WAIT_DONE;
          end else if (timed_out) begin
            uart_start_transmit <= 1'b0;
            err_flag            <= 1'b1;
            timer               <= '0;
            state               <= FINISH;
          end
        end
        WAIT_DONE: begin
          if (tx_done_sync) begin
            timer <= '0;
            if (idx == len_q - 1'b1) begin
              state <= FINISH;
            end else begin
              idx            <= idx + 1'b1;
              uart_data      <= byte_at(pkt_q, idx + 1'b1);
              uart_load_data <= 1'b1;
              state          <= LOAD;
            end
          end else if (timed_out) begin
            err_flag <= 1'b1;
            timer    <= '0;
            state    <= FINISH;
          end
        end
        FINISH: begin
          done0      <= ~owner;
          done1      <= owner;
          error      <= err_flag;
          err_flag   <= 1'b0;
          last_grant <= owner;
          busy       <= 1'b0;
          timer      <= '0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          timer <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_packet_tx_arbiter.sv
// Directed bench for uart_packet_tx_arbiter with a small behavioural uart_tx model.
`timescale 1ns/1ps
module tb_uart_packet_tx_arbiter;

  localparam int PKT_BYTES   = 18;
  localparam int LEN_W       = 5;
  localparam int HOLD_CYCLES = 4;
  localparam int TIMEOUT     = 100;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   soft_reset;
  logic                   req0;
  logic                   req1;
  logic [8*PKT_BYTES-1:0] pkt0;
  logic [8*PKT_BYTES-1:0] pkt1;
  logic [LEN_W-1:0]       len0;
  logic [LEN_W-1:0]       len1;
  logic                   grant0;
  logic                   grant1;
  logic                   done0;
  logic                   done1;
  logic                   error;
  logic                   busy;
  logic [7:0]             uart_data;
  logic                   uart_load_data;
  logic                   uart_start_transmit;
  logic                   uart_tx_done;

  int compared   = 0;
  int mismatched = 0;

  logic       stuck;
  int         busy_cnt;
  logic [7:0] sent_q[$];
  int         load_rises = 0;
  logic       load_prev  = 1'b0;

  int grant_log[$];
  int grant_cyc[$];
  int done_log[$];
  int err_log[$];
  int done_cyc[$];
  int dual_grant;
  int stray_error;
  int rem0;
  int rem1;
  int wait_cyc;
  int pulse_seen;

  always #5 clk = ~clk;

  uart_packet_tx_arbiter #(
    .PKT_BYTES  (PKT_BYTES),
    .LEN_W      (LEN_W),
    .HOLD_CYCLES(HOLD_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .soft_reset         (soft_reset),
    .req0               (req0),
    .req1               (req1),
    .pkt0               (pkt0),
    .pkt1               (pkt1),
    .len0               (len0),
    .len1               (len1),
    .grant0             (grant0),
    .grant1             (grant1),
    .done0              (done0),
    .done1              (done1),
    .error              (error),
    .busy               (busy),
    .uart_data          (uart_data),
    .uart_load_data     (uart_load_data),
    .uart_start_transmit(uart_start_transmit),
    .uart_tx_done       (uart_tx_done)
  );

  // Transmitter model: goes busy on start, idles again a few cycles later unless stuck.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      uart_tx_done <= 1'b1;
      busy_cnt     <= 0;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end else if (!uart_tx_done && !stuck) begin
      uart_tx_done <= 1'b1;
    end else if (uart_tx_done && uart_start_transmit) begin
      uart_tx_done <= 1'b0;
      busy_cnt     <= 6;
    end
  end

  always @(posedge clk) begin
    if (uart_load_data && !load_prev) begin
      sent_q.push_back(uart_data);
      load_rises++;
    end
    load_prev <= uart_load_data;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_logs();
    grant_log.delete();
    grant_cyc.delete();
    done_log.delete();
    err_log.delete();
    done_cyc.delete();
    sent_q.delete();
    load_rises  = 0;
    dual_grant  = 0;
    stray_error = 0;
    rem0        = 0;
    rem1        = 0;
  endtask

  // Plays both requesters: drops req on grant, re-raises while repeats remain.
  task automatic apply_stimulus(input int target_dones, input int max_cycles);
    int dones = 0;
    int cyc   = 0;
    while (dones < target_dones && cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      if (grant0 && grant1) dual_grant++;
      if (grant0 || grant1) begin
        grant_log.push_back(grant1 ? 1 : 0);
        grant_cyc.push_back(cyc);
        if (grant0) req0 = 1'b0;
        if (grant1) req1 = 1'b0;
      end
      if (done0 || done1) begin
        done_log.push_back(done1 ? 1 : 0);
        err_log.push_back(error ? 1 : 0);
        done_cyc.push_back(cyc);
        dones++;
        if (done0 && rem0 > 0) begin
          rem0--;
          req0 = 1'b1;
        end
        if (done1 && rem1 > 0) begin
          rem1--;
          req1 = 1'b1;
        end
      end else if (error) begin
        stray_error++;
      end
    end
    check_output("dones_within_budget", 32'(dones), 32'(target_dones));
  endtask

  initial begin
    reset      = 1'b0;
    soft_reset = 1'b0;
    req0       = 1'b0;
    req1       = 1'b0;
    pkt0       = '0;
    pkt1       = '0;
    len0       = '0;
    len1       = '0;
    stuck      = 1'b0;
    clear_logs();

    repeat (3) @(negedge clk);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_grant", 32'({grant1, grant0}), 32'd0);
    check_output("rst_done_err", 32'({done1, done0, error}), 32'd0);
    check_output("rst_uart_data", 32'(uart_data), 32'd0);
    check_output("rst_strobes", 32'({uart_load_data, uart_start_transmit}), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] three-byte packet on requester 0");
    clear_logs();
    pkt0[23:0] = 24'hCCBBAA;
    len0       = 5'd3;
    req0       = 1'b1;
    apply_stimulus(1, 400);
    check_output("t1_grant_owner", 32'(grant_log[0]), 32'd0);
    check_output("t1_grant_latency", 32'(grant_cyc[0]), 32'd1);
    check_output("t1_bytes_sent", 32'(sent_q.size()), 32'd3);
    check_output("t1_byte0", 32'(sent_q[0]), 32'hAA);
    check_output("t1_byte1", 32'(sent_q[1]), 32'hBB);
    check_output("t1_byte2", 32'(sent_q[2]), 32'hCC);
    check_output("t1_done_owner", 32'(done_log[0]), 32'd0);
    check_output("t1_error", 32'(err_log[0]), 32'd0);
    @(negedge clk);
    check_output("t1_idle_after", 32'(busy), 32'd0);

    $display("[TB] soft reset in idle, then round-robin with both requesters");
    soft_reset = 1'b1;
    @(negedge clk);
    soft_reset = 1'b0;
    clear_logs();
    pkt0       = '0;
    pkt0[7:0]  = 8'h11;
    pkt1       = '0;
    pkt1[7:0]  = 8'h22;
    len0       = 5'd1;
    len1       = 5'd1;
    rem0       = 1;
    rem1       = 1;
    req0       = 1'b1;
    req1       = 1'b1;
    apply_stimulus(4, 800);
    check_output("rr_grant_count", 32'(grant_log.size()), 32'd4);
    check_output("rr_grants", 32'({grant_log[0][0], grant_log[1][0], grant_log[2][0], grant_log[3][0]}), 32'b0101);
    check_output("rr_dones", 32'({done_log[0][0], done_log[1][0], done_log[2][0], done_log[3][0]}), 32'b0101);
    check_output("rr_errors", 32'(err_log[0] + err_log[1] + err_log[2] + err_log[3]), 32'd0);
    check_output("rr_bytes", {sent_q[0], sent_q[1], sent_q[2], sent_q[3]}, 32'h11221122);
    check_output("rr_dual_grant", 32'(dual_grant), 32'd0);

    $display("[TB] zero and oversize lengths");
    clear_logs();
    len1 = 5'd0;
    req1 = 1'b1;
    apply_stimulus(1, 50);
    check_output("len0_grant", 32'(grant_log[0]), 32'd1);
    check_output("len0_done_owner", 32'(done_log[0]), 32'd1);
    check_output("len0_error", 32'(err_log[0]), 32'd1);
    check_output("len0_no_load", 32'(load_rises), 32'd0);
    clear_logs();
    len0 = 5'd19;
    req0 = 1'b1;
    apply_stimulus(1, 50);
    check_output("len19_done_owner", 32'(done_log[0]), 32'd0);
    check_output("len19_error", 32'(err_log[0]), 32'd1);
    check_output("len19_no_load", 32'(load_rises), 32'd0);
    check_output("len19_stray_err", 32'(stray_error), 32'd0);

    $display("[TB] transmitter stuck busy after first start");
    clear_logs();
    stuck      = 1'b1;
    pkt0       = '0;
    pkt0[15:0] = 16'h8877;
    len0       = 5'd2;
    req0       = 1'b1;
    apply_stimulus(1, 400);
    check_output("to_error", 32'(err_log[0]), 32'd1);
    check_output("to_done_owner", 32'(done_log[0]), 32'd0);
    check_output("to_latency_window",
                 32'((done_cyc[0] - grant_cyc[0] >= 100) && (done_cyc[0] - grant_cyc[0] <= 130)), 32'd1);
    check_output("to_strobes_low", 32'({uart_load_data, uart_start_transmit}), 32'd0);
    check_output("to_bytes_sent", 32'(sent_q.size()), 32'd1);
    check_output("to_byte0", 32'(sent_q[0]), 32'h77);
    stuck = 1'b0;
    clear_logs();
    pkt1      = '0;
    pkt1[7:0] = 8'h5A;
    len1      = 5'd1;
    req1      = 1'b1;
    apply_stimulus(1, 400);
    check_output("to_next_error", 32'(err_log[0]), 32'd0);
    check_output("to_next_byte", 32'(sent_q[0]), 32'h5A);

    $display("[TB] soft reset during byte 2 of 18");
    clear_logs();
    for (int k = 0; k < PKT_BYTES; k++) pkt0[8*k +: 8] = 8'(k + 1);
    len0     = 5'd18;
    req0     = 1'b1;
    wait_cyc = 0;
    while (sent_q.size() < 2 && wait_cyc < 500) begin
      @(negedge clk);
      wait_cyc++;
      if (grant0) req0 = 1'b0;
    end
    check_output("sr_reached_byte2", 32'(sent_q.size()), 32'd2);
    soft_reset = 1'b1;
    @(negedge clk);
    soft_reset = 1'b0;
    check_output("sr_busy", 32'(busy), 32'd0);
    check_output("sr_uart_data", 32'(uart_data), 32'd0);
    check_output("sr_strobes", 32'({uart_load_data, uart_start_transmit}), 32'd0);
    pulse_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done0 || done1 || error) pulse_seen++;
    end
    check_output("sr_no_done", 32'(pulse_seen), 32'd0);
    clear_logs();
    len0 = 5'd2;
    req0 = 1'b1;
    apply_stimulus(1, 400);
    check_output("sr_restart_bytes", 32'({sent_q[0], sent_q[1]}), 32'h0102);
    check_output("sr_restart_error", 32'(err_log[0]), 32'd0);

    $display("[TB] asynchronous reset during LOAD");
    clear_logs();
    len0     = 5'd1;
    req0     = 1'b1;
    wait_cyc = 0;
    while (!uart_load_data && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
      if (grant0) req0 = 1'b0;
    end
    check_output("ar_in_load", 32'(uart_load_data), 32'd1);
    reset = 1'b0;
    #1;
    check_output("ar_load_low", 32'(uart_load_data), 32'd0);
    check_output("ar_busy_low", 32'(busy), 32'd0);
    check_output("ar_data_zero", 32'(uart_data), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_logs();
    len0 = 5'd1;
    len1 = 5'd1;
    req0 = 1'b1;
    req1 = 1'b1;
    apply_stimulus(2, 400);
    check_output("ar_first_grant", 32'(grant_log[0]), 32'd0);
    check_output("ar_second_grant", 32'(grant_log[1]), 32'd1);
    check_output("ar_done_order", 32'({done_log[0][0], done_log[1][0]}), 32'b01);
    check_output("ar_errors", 32'(err_log[0] + err_log[1]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_packet_tx_arbiter.md
# uart_packet_tx_arbiter

Shares one `uart_tx` instance between two packet sources (0: command path, 1: response path) and serializes a latched wide packet into it one byte at a time. It owns the load/start/finish handshake toward the baud-clocked transmitter, arbitrates round-robin, and reports per-requester completion or error. It sits between the encoders/decoders and a `uart_tx` (host or BLE side) in `top_level`.

## Interface

- `PKT_BYTES`, 18: maximum packet length in bytes (packet width = 8*PKT_BYTES).
- `LEN_W`, 5: width of length inputs; must hold PKT_BYTES.
- `HOLD_CYCLES`, 5208: clk cycles `uart_load_data` is held high (≥ one baud period, CLOCK_FREQ/BAUD_RATE).
- `TIMEOUT`, 4000000: clk cycles allowed for each `uart_tx_done` wait.

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `soft_reset` in 1: synchronous abort to IDLE, active-high.
- `req0`, `req1` in 1: level request; held until matching `grant` pulse.
- `pkt0`, `pkt1` in 8*PKT_BYTES: packet; byte k = bits [8k+7:8k], byte 0 sent first.
- `len0`, `len1` in LEN_W: bytes to send, valid range 1..PKT_BYTES.
- `grant0`, `grant1` out 1: one-cycle pulse; packet/len latched on this edge.
- `done0`, `done1` out 1: one-cycle pulse, packet completed (success or error).
- `error` out 1: one-cycle pulse coincident with `doneN` when the transfer failed.
- `busy` out 1: high in every state except IDLE.
- `uart_data` out 8: byte to `uart_tx.data`.
- `uart_load_data` out 1: to `uart_tx.load_data`.
- `uart_start_transmit` out 1: to `uart_tx.start_transmit`.
- `uart_tx_done` in 1: `uart_tx.tx_finish`; level, high = transmitter idle. Passed through a 2-flop synchronizer inside the block.

## Operation

- Reset (async, `reset`=0): all outputs 0, state IDLE, byte index 0, round-robin pointer = "last granted 1" (requester 0 wins first tie), timers 0.
- `soft_reset`=1: same values at the next edge; no `done`/`error` pulse for an aborted packet. `soft_reset` takes priority over all FSM activity.
- IDLE: if exactly one `reqN`, grant it; if both, grant the one not granted last. Latch pkt, len, owner; pulse `grantN`; index←0. If latched len = 0 or > PKT_BYTES → FINISH with error, nothing sent to the UART.
- WAIT_IDLE: wait for synced `uart_tx_done`=1 (timer running) → LOAD.
- LOAD: `uart_data` ← byte[index]; `uart_load_data`=1 for HOLD_CYCLES cycles, then 0 → START.
- START: `uart_start_transmit`=1 and held until synced `uart_tx_done`=0 observed (timer running) → WAIT_DONE.
- WAIT_DONE: `uart_start_transmit`=0; wait synced `uart_tx_done`=1 (timer running). Then if index = len−1 → FINISH, else index+1 → LOAD.
- FINISH: one cycle; pulse `doneN` for owner, `error` if flagged; update round-robin pointer; → IDLE.
- Timer: cleared on every state entry; in any waiting state reaching TIMEOUT → drop `uart_load_data`/`uart_start_transmit`, set error, → FINISH. Remaining bytes are not sent.
- `uart_data` holds its last value outside LOAD; it is 0 only after reset/soft_reset.

## Timing

- Grant: `grantN` asserts the cycle after `reqN` is sampled high in IDLE; requester may drop `reqN` the cycle after `grantN`.
- Requests arriving while busy wait; no request is lost or double-granted.
- Minimum per-byte cost: 2 (sync) + HOLD_CYCLES + start/finish round trip of `uart_tx`.
- Back-to-back: after FINISH, IDLE may grant the other requester on the next cycle (one idle cycle between packets).
- Tx_done already 0 when entering WAIT_IDLE: block waits; never loads into a busy transmitter.
- `uart_tx_done` glitch high for < 2 cycles during WAIT_DONE is ignored only to synchronizer extent; no extra filtering.
- Reset asserted mid-byte: outputs go to 0 immediately (async); no `done` pulse.

## Test plan

- len0=3, pkt0 low bytes 0xCC_BB_AA, UART model idle → grant0 pulse, bytes 0xAA,0xBB,0xCC loaded in order, one done0, error=0.
- req0 and req1 high together, both held for repeated requests → grants 0,1,0,1; each done matches its grant owner.
- len1=0 → grant1, done1 and error same cycle, `uart_load_data` never asserted.
- UART model holds tx_done=0 after first start (TIMEOUT=100) → error+done0 ≈100 cycles later, strobes low, next request served normally.
- soft_reset pulsed during byte 2 of 18 → IDLE next cycle, no done/error, all outputs 0, new req0 starts at byte 0.
- reset low during LOAD → outputs 0 asynchronously; after release, simultaneous requests grant requester 0 first.
